// File: rtl/board_pkg.sv
// Board-level constants for the iCEBreaker pixel-clock domain.
// Shared by button handling and anything else that needs clock-derived timing.
package board_pkg;

  localparam int PIXEL_CLK_HZ = 25_125_000;
  localparam int BTN_COUNT = 4;
  localparam logic [3:0] BTN_ACTIVE_LOW = 4'b0001;
  localparam int DEBOUNCE_MS = 10;

  // Pixel-clock cycles in a whole number of milliseconds.
  function automatic int debounce_cycles(input int ms);
    return (PIXEL_CLK_HZ / 1000) * ms;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button bit: 2-FF synchroniser, stability counter, level, press/release pulses, toggle.
// Latency: level and pulse change DEBOUNCE_CYCLES+1 edges after s1 first samples a stable new value.
// No backpressure: pulses are single-cycle and free-running.
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 251250
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic toggle
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1            <= 1'b0;
      s2            <= 1'b0;
      cnt           <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      toggle        <= 1'b0;
    end else begin
      s1            <= din;
      s2            <= s1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      // Any sample matching the current level restarts the stability window.
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt           <= '0;
        level         <= s2;
        press_pulse   <= s2;
        release_pulse <= ~s2;
        toggle        <= toggle ^ s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Normalises button polarity and debounces each channel independently in the clk domain.
// Latency: DEBOUNCE_CYCLES+1 or +2 cycles from raw pin change; all outputs registered.
// No backpressure: press/release are one-cycle pulses, level and toggle are held.
module button_conditioner
  import board_pkg::*;
#(
  parameter int             N               = BTN_COUNT,
  parameter int             DEBOUNCE_CYCLES = debounce_cycles(DEBOUNCE_MS),
  parameter logic [N-1:0]   ACTIVE_LOW      = N'(BTN_ACTIVE_LOW)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn_raw,
  output logic [N-1:0] btn_level,
  output logic [N-1:0] btn_press,
  output logic [N-1:0] btn_release,
  output logic [N-1:0] btn_toggle
);

  // After this XOR a 1 always means pressed.
  logic [N-1:0] norm;
  assign norm = btn_raw ^ ACTIVE_LOW;

  for (genvar i = 0; i < N; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .din          (norm[i]),
      .level        (btn_level[i]),
      .press_pulse  (btn_press[i]),
      .release_pulse(btn_release[i]),
      .toggle       (btn_toggle[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Cycle-by-cycle vector table for button_conditioner with DEBOUNCE_CYCLES=4, bit 0 active-low.
module tb_button_conditioner;

  localparam int         N  = 4;
  localparam int         DC = 4;
  localparam logic [3:0] AL = 4'b0001;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_raw;
  logic [3:0] btn_level, btn_press, btn_release, btn_toggle;

  always #5 clk = ~clk;

  button_conditioner #(
    .N(N), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(AL)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_toggle(btn_toggle)
  );

  typedef struct packed {
    logic       rst;
    logic [3:0] raw;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] tog;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input int n, input logic r, input logic [3:0] raw,
                     input logic [3:0] lvl, input logic [3:0] prs,
                     input logic [3:0] rel, input logic [3:0] tog);
    vec_t v;
    v = '{rst: r, raw: raw, lvl: lvl, prs: prs, rel: rel, tog: tog};
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Inputs are applied just after an edge; outputs are sampled 1 time unit after the next edge.
  task automatic apply(input logic r, input logic [3:0] raw);
    rst     = r;
    btn_raw = raw;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int press_at;
    int press_cnt;
    int pulse_cnt;
    rst     = 1'b1;
    btn_raw = 4'b0001;

    // Reset, then idle for 20 cycles.
    add(2,  1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(20, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // Clean press/release on bit 1; accepted on the 6th sampled edge.
    add(5,  0, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1,  0, 4'b0011, 4'b0010, 4'b0010, 4'b0000, 4'b0010);
    add(14, 0, 4'b0011, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    add(5,  0, 4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    add(1,  0, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0010);
    add(6,  0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
    // Bounce on bit 2: highs of 1, 2, 3 cycles between single lows, then steady.
    add(1,  0, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
    add(1,  0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
    add(2,  0, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
    add(1,  0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
    add(3,  0, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
    add(1,  0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
    add(5,  0, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
    add(1,  0, 4'b0101, 4'b0100, 4'b0100, 4'b0000, 4'b0110);
    add(4,  0, 4'b0101, 4'b0100, 4'b0000, 4'b0000, 4'b0110);
    add(5,  0, 4'b0001, 4'b0100, 4'b0000, 4'b0000, 4'b0110);
    add(1,  0, 4'b0001, 4'b0000, 4'b0000, 4'b0100, 4'b0110);
    add(4,  0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0110);
    // Active-low bit 0: two full press/release cycles bring toggle back to 0.
    for (int k = 0; k < 2; k++) begin
      logic [3:0] tog_before, tog_after;
      tog_before = (k == 0) ? 4'b0110 : 4'b0111;
      tog_after  = (k == 0) ? 4'b0111 : 4'b0110;
      add(5, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, tog_before);
      add(1, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000, tog_after);
      add(4, 0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, tog_after);
      add(5, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, tog_after);
      add(1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, tog_after);
      add(4, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, tog_after);
    end
    // Simultaneous press of bits 1 and 3.
    add(5,  0, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0110);
    add(1,  0, 4'b1011, 4'b1010, 4'b1010, 4'b0000, 4'b1100);
    add(4,  0, 4'b1011, 4'b1010, 4'b0000, 4'b0000, 4'b1100);
    add(5,  0, 4'b0001, 4'b1010, 4'b0000, 4'b0000, 4'b1100);
    add(1,  0, 4'b0001, 4'b0000, 4'b0000, 4'b1010, 4'b1100);
    add(4,  0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b1100);

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst, vecs[i].raw);
      chk($sformatf("row%0d level",   i), btn_level,   vecs[i].lvl);
      chk($sformatf("row%0d press",   i), btn_press,   vecs[i].prs);
      chk($sformatf("row%0d release", i), btn_release, vecs[i].rel);
      chk($sformatf("row%0d toggle",  i), btn_toggle,  vecs[i].tog);
    end

    // Reset while bit 2 is mid-count (cnt reaches 2 after the 4th edge).
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 4'b0101);
      chk($sformatf("precount%0d level", i), btn_level, 4'b0000);
      chk($sformatf("precount%0d press", i), btn_press, 4'b0000);
    end
    apply(1'b1, 4'b0101);
    chk("midrst level",   btn_level,   4'b0000);
    chk("midrst press",   btn_press,   4'b0000);
    chk("midrst release", btn_release, 4'b0000);
    chk("midrst toggle",  btn_toggle,  4'b0000);

    // Held button must be re-accepted on the 6th edge after reset falls, once.
    press_at  = 0;
    press_cnt = 0;
    pulse_cnt = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      apply(1'b0, 4'b0101);
      if (btn_press[2]) begin
        press_cnt++;
        if (press_at == 0) press_at = cyc;
      end
      if (btn_release != 4'b0000 || (btn_press & 4'b1011) != 4'b0000) pulse_cnt++;
    end
    chk_int("rearm press edge",  press_at,  6);
    chk_int("rearm press count", press_cnt, 1);
    chk_int("rearm stray pulses", pulse_cnt, 0);
    chk("rearm level",  btn_level,  4'b0100);
    chk("rearm toggle", btn_toggle, 4'b0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Synchronises, debounces and edge-detects the iCEBreaker push-buttons (BTN_N, BTN1..BTN3) in the `clk_pixel` domain. It sits directly upstream of the demo core and the LED logic, and replaces the raw asynchronous button wires. It produces clean levels, one-cycle press/release pulses and per-button toggle state. The demo core's `ui_in` and the LED assignments consume these outputs.

## Interface
Parameters:
- `N`, 4: number of button channels; bit 0 = BTN_N, bits 1..3 = BTN1..BTN3.
- `DEBOUNCE_CYCLES`, 251250: consecutive stable cycles required before accepting a change (10 ms at 25.125 MHz). Legal range ≥ 2.
- `ACTIVE_LOW`, 4'b0001: per-bit mask. A set bit means the raw pin reads 0 when pressed.

Ports:
- `clk`, in, 1: pixel clock (`clk_pixel`, 25.125 MHz).
- `rst`, in, 1: reset. Synchronous and active-high; one clock, all state reset on the `clk` edge.
- `btn_raw`, in, N: asynchronous raw button pins.
- `btn_level`, out, N: debounced pressed state (1 = pressed).
- `btn_press`, out, N: one-cycle pulse on accepted 0→1 of `btn_level`.
- `btn_release`, out, N: one-cycle pulse on accepted 1→0 of `btn_level`.
- `btn_toggle`, out, N: flips on every `btn_press`.

## Operation
- Polarity normalisation (combinational): `norm = btn_raw ^ ACTIVE_LOW`. After this, 1 = pressed.
- Per channel, a 2-FF synchroniser: `s1 <= norm`, `s2 <= s1`.
- Debounce counter `cnt`, width `$clog2(DEBOUNCE_CYCLES)`. Each cycle:
  - if `s2 == btn_level`: `cnt <= 0`.
  - else if `cnt == DEBOUNCE_CYCLES-1`: `btn_level <= s2`, `cnt <= 0`, assert the press or release pulse.
  - else: `cnt <= cnt + 1`.
- Any bounce back to the current level clears `cnt`. A change is accepted only after DEBOUNCE_CYCLES consecutive differing samples of `s2`.
- `btn_press` / `btn_release` are registered. They assert in the same cycle `btn_level` changes and deassert the next cycle. They are never both high on the same channel.
- `btn_toggle <= btn_toggle ^ btn_press`. It updates in the same cycle `btn_press` is high.
- Channels are fully independent. Simultaneous presses on several channels produce simultaneous pulses.
- Reset values: `s1`, `s2`, `cnt`, `btn_level`, `btn_press`, `btn_release`, `btn_toggle` all 0.
  - A button held through reset is therefore accepted as a press DEBOUNCE_CYCLES+2 edges after `rst` falls. This is intended.
- `rst` asserted mid-count discards the count. No pulse is emitted on the reset edge.

## Timing
- Let edge E be the first edge where `s1` samples a new normalised value that then stays stable.
  - `s2` changes at E+1.
  - `cnt` reaches 1 at E+2 and reaches DEBOUNCE_CYCLES-1 at E+DEBOUNCE_CYCLES.
  - `btn_level` and the pulse change at edge E+DEBOUNCE_CYCLES+1.
- Latency from the raw pin change is DEBOUNCE_CYCLES+1 or DEBOUNCE_CYCLES+2 cycles, depending on sampling phase.
- Minimum accepted pulse width is DEBOUNCE_CYCLES cycles. Shorter glitches produce no output change.
- Counter saturation cannot occur: it wraps to 0 only through the accept or mismatch paths.
- Outputs are registered with no combinational path from `btn_raw`.

## Structure
- Shared package `board_pkg`:
  - `PIXEL_CLK_HZ = 25_125_000`.
  - `BTN_COUNT = 4`.
  - `BTN_ACTIVE_LOW = 4'b0001`.
  - `DEBOUNCE_MS = 10`.
  - A function computing cycles from milliseconds.
- Natural sub-module `debounce_channel`: one synchroniser, counter, level, pulses and toggle for a single bit.
  - `button_conditioner` instantiates N of these in a generate loop and applies the polarity mask.

## Test plan
All scenarios run with DEBOUNCE_CYCLES = 4, ACTIVE_LOW = 4'b0001.
- Reset with all buttons idle (`btn_raw` = 4'b0001) → all outputs 0 for 20 cycles after `rst` deasserts; no pulses.
- Clean press on bit 1 (0→1, held 20 cycles) → `btn_level[1]` rises 5–6 cycles after the pin change, `btn_press[1]` high exactly 1 cycle, `btn_toggle[1]` = 1; release gives `btn_release[1]` 1-cycle pulse and `btn_level[1]` = 0.
- Bounce on bit 2: pulses of 1, 2 and 3 cycles separated by 1-cycle lows, then steady → no output change during the bounce; exactly one `btn_press[2]`, 5–6 cycles after the final steady edge.
- Active-low bit 0: drive `btn_raw[0]` 1→0 and hold → `btn_level[0]` = 1 and one `btn_press[0]`; two full press/release cycles return `btn_toggle[0]` to 0.
- Simultaneous press on bits 1 and 3 in the same cycle → `btn_press[1]` and `btn_press[3]` asserted in the same cycle; bits 0 and 2 unchanged.
- `rst` pulsed for 1 cycle while bit 2 `cnt` = 2 → all outputs 0 next cycle, no pulse. Held button re-accepted 6 cycles after `rst` falls with a single `btn_press[2]`.
